// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripheral block: register offsets,
// TCON bit positions, hex-to-segment glyph table and the debounce interval.
package periph_pkg;

    localparam logic [4:0] OffTh     = 5'h00;
    localparam logic [4:0] OffTl     = 5'h04;
    localparam logic [4:0] OffTcon   = 5'h08;
    localparam logic [4:0] OffLed    = 5'h0C;
    localparam logic [4:0] OffSwitch = 5'h10;
    localparam logic [4:0] OffDigi   = 5'h14;
    localparam logic [4:0] OffBlank  = 5'h18;

    localparam int unsigned TconRun     = 0;
    localparam int unsigned TconIrqEn   = 1;
    localparam int unsigned TconIrqFlag = 2;

    localparam int unsigned DEBOUNCE_CYC = 32'd1 << 16;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/periph_if.sv
// Data-bus port between the MEM stage (master) and the peripheral block (slave).
interface periph_if;

    logic [31:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output addr, wr_en, rd_en, wdata, input rdata, hit);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata, hit);

endinterface

// File: rtl/seg7_decode.sv
// One seven-segment digit: registered hex decode with blanking, active-low output.
module seg7_decode
    import periph_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_d, seg_q;

    always_comb begin
        seg_d = blank_i ? 7'h7F : hex2seg(nibble_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_q <= 7'h7F;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/periph_mmio.sv
// Peripheral block on the data bus: interval timer + irq, LEDs, synchronised switches and
// hex seven-segment digits. Define PERIPH_DEBOUNCE_EN to add per-bit switch debouncers.
module periph_mmio
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned SW_W       = 8,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TIMER_W    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    periph_if.slave                 bus,
    input  logic [SW_W-1:0]         switch_i,
    output logic [LED_W-1:0]        led_o,
    output logic [NUM_DIGITS*7-1:0] digi_out_o,
    output logic                    irq_o
);

    localparam logic [TIMER_W-1:0] TlMax = '1;

    logic [TIMER_W-1:0]      th_d, th_q, tl_d, tl_q;
    logic [2:0]              tcon_d, tcon_q;
    logic [LED_W-1:0]        led_d, led_q;
    logic [4*NUM_DIGITS-1:0] digi_d, digi_q;
    logic [NUM_DIGITS-1:0]   blank_d, blank_q;
    logic [SW_W-1:0]         sw_sync1_q, sw_sync2_q, sw_val;
    logic                    hit, wr, reload;
    logic [4:0]              offs;
    logic                    unused_bits;

    // Window is 0x20-aligned, so the upper address bits alone select it.
    assign hit         = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign offs        = {bus.addr[4:2], 2'b00};
    assign wr          = bus.wr_en & hit;
    assign reload      = tcon_q[TconRun] && (tl_q == TlMax);
    assign bus.hit     = hit;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    always_comb begin
        th_d    = th_q;
        tl_d    = tl_q;
        tcon_d  = tcon_q;
        led_d   = led_q;
        digi_d  = digi_q;
        blank_d = blank_q;
        if (tcon_q[TconRun]) begin
            tl_d = reload ? th_q : tl_q + TIMER_W'(1);
        end
        if (wr) begin
            case (offs)
                OffTh:    th_d    = bus.wdata[TIMER_W-1:0];
                OffTl:    tl_d    = bus.wdata[TIMER_W-1:0];
                OffTcon:  tcon_d  = bus.wdata[2:0];
                OffLed:   led_d   = bus.wdata[LED_W-1:0];
                OffDigi:  digi_d  = bus.wdata[4*NUM_DIGITS-1:0];
                OffBlank: blank_d = bus.wdata[NUM_DIGITS-1:0];
                default:  ;
            endcase
        end
        // Overflow sets the flag even if the CPU writes TCON in the same cycle.
        if (reload && tcon_q[TconIrqEn]) begin
            tcon_d[TconIrqFlag] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            th_q       <= '0;
            tl_q       <= '0;
            tcon_q     <= '0;
            led_q      <= '0;
            digi_q     <= '0;
            blank_q    <= '1;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            th_q       <= th_d;
            tl_q       <= tl_d;
            tcon_q     <= tcon_d;
            led_q      <= led_d;
            digi_q     <= digi_d;
            blank_q    <= blank_d;
            sw_sync1_q <= switch_i;
            sw_sync2_q <= sw_sync1_q;
        end
    end

`ifdef PERIPH_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC) + 1;

    for (genvar gi = 0; gi < SW_W; gi++) begin : g_debounce
        logic [CntW-1:0] cnt_q;
        logic            deb_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (sw_sync2_q[gi] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
                cnt_q <= '0;
                deb_q <= sw_sync2_q[gi];
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end

        assign sw_val[gi] = deb_q;
    end
`else
    assign sw_val = sw_sync2_q;
`endif

    always_comb begin
        bus.rdata = '0;
        if (bus.rd_en && hit) begin
            case (offs)
                OffTh:     bus.rdata = 32'(th_q);
                OffTl:     bus.rdata = 32'(tl_q);
                OffTcon:   bus.rdata = 32'(tcon_q);
                OffLed:    bus.rdata = 32'(led_q);
                OffSwitch: bus.rdata = 32'(sw_val);
                OffDigi:   bus.rdata = 32'(digi_q);
                OffBlank:  bus.rdata = 32'(blank_q);
                default:   bus.rdata = '0;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        seg7_decode u_seg7_decode (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .nibble_i (digi_q[4*gi +: 4]),
            .blank_i  (blank_q[gi]),
            .seg_o    (digi_out_o[7*gi +: 7])
        );
    end

    assign led_o = led_q;
    assign irq_o = tcon_q[TconIrqFlag];

endmodule

// File: tb/tb_periph_mmio.sv
// Directed self-checking bench for periph_mmio: timer/irq, digits, switches, LEDs,
// address decode and asynchronous reset.
module tb_periph_mmio;

    localparam logic [31:0] Base = 32'h4000_0000;
    localparam logic [27:0] DigiDark = {4{7'h7F}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic [27:0] digi;
    logic        irq;
    logic [31:0] rd;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    periph_if bus ();

    periph_mmio #(
        .BASE_ADDR  (Base),
        .LED_W      (8),
        .SW_W       (8),
        .NUM_DIGITS (4),
        .TIMER_W    (32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .switch_i   (sw),
        .led_o      (led),
        .digi_out_o (digi),
        .irq_o      (irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        @(negedge clk);
        bus.addr  = Base + off;
        bus.wdata = data;
        bus.wr_en = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
        bus.addr  = Base + off;
        bus.rd_en = 1'b1;
        #1;
        data      = bus.rdata;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        sw        = 8'h00;

        // Reset state
        #12;
        check("rst_led", 64'(led), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        check("rst_digi", 64'(digi), 64'(DigiDark));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(32'h18, rd); check("rst_blank", 64'(rd), 64'hF);
        bus_read(32'h08, rd); check("rst_tcon", 64'(rd), 64'h0);
        bus_read(32'h04, rd); check("rst_tl", 64'(rd), 64'h0);

        // Timer overflow and reload
        bus_write(32'h00, 32'hFFFF_FFF0);
        bus_write(32'h04, 32'hFFFF_FFFE);
        bus_write(32'h08, 32'h0000_0003);
        bus_read(32'h04, rd); check("tl_start", 64'(rd), 64'hFFFF_FFFE);
        @(posedge clk); #1;
        bus_read(32'h04, rd); check("tl_max", 64'(rd), 64'hFFFF_FFFF);
        check("irq_pre", 64'(irq), 64'h0);
        @(posedge clk); #1;
        bus_read(32'h04, rd); check("tl_reload", 64'(rd), 64'hFFFF_FFF0);
        check("irq_set", 64'(irq), 64'h1);
        bus_read(32'h08, rd); check("tcon_flag", 64'(rd), 64'h7);

        // Clear flag, keep running, then freeze
        bus_write(32'h08, 32'h0000_0003);
        check("irq_clr", 64'(irq), 64'h0);
        bus_read(32'h04, rd); check("tl_run1", 64'(rd), 64'hFFFF_FFF1);
        bus_read(32'h08, rd); check("tcon_rb", 64'(rd), 64'h3);
        @(posedge clk); #1;
        bus_read(32'h04, rd); check("tl_run2", 64'(rd), 64'hFFFF_FFF2);
        bus_write(32'h08, 32'h0000_0000);
        repeat (3) @(posedge clk);
        #1;
        bus_read(32'h04, rd); check("tl_frozen", 64'(rd), 64'hFFFF_FFF3);

        // Seven-segment digits
        bus_write(32'h14, 32'h0000_A1F0);
        bus_write(32'h18, 32'h0000_0000);
        check("digi_lat", 64'(digi), 64'(DigiDark));
        @(posedge clk); #1;
        check("digi_a1f0", 64'(digi), 64'({7'h08, 7'h79, 7'h0E, 7'h40}));
        bus_write(32'h18, 32'h0000_0004);
        @(posedge clk); #1;
        check("digi_blank2", 64'(digi), 64'({7'h08, 7'h7F, 7'h0E, 7'h40}));
        bus_write(32'h18, 32'h0000_0000);
        bus_write(32'h14, 32'hFFFF_3E69);
        @(posedge clk); #1;
        check("digi_3e69", 64'(digi), 64'({7'h30, 7'h06, 7'h02, 7'h10}));
        bus_read(32'h14, rd); check("digi_rb", 64'(rd), 64'h3E69);

        // Switch synchroniser latency
        @(negedge clk);
        sw = 8'h5A;
`ifdef PERIPH_DEBOUNCE_EN
        repeat (2 ** 16 + 8) @(posedge clk);
        #1;
        bus_read(32'h10, rd); check("sw_deb", 64'(rd), 64'h5A);
`else
        @(posedge clk); #1;
        bus_read(32'h10, rd); check("sw_lat1", 64'(rd), 64'h00);
        @(posedge clk); #1;
        bus_read(32'h10, rd); check("sw_lat2", 64'(rd), 64'h5A);
`endif

        // LED register and address decode
        bus_write(32'h0C, 32'hFFFF_FFA5);
        check("led_out", 64'(led), 64'hA5);
        bus_read(32'h0C, rd); check("led_rb", 64'(rd), 64'hA5);
        bus_write(32'h1C, 32'h1234_5678);
        bus_read(32'h1C, rd); check("unmapped_rd", 64'(rd), 64'h0);
        check("hit_1c", 64'(bus.hit), 64'h1);
        bus_read(32'h20, rd); check("beyond_rd", 64'(rd), 64'h0);
        check("hit_20", 64'(bus.hit), 64'h0);
        bus.addr = Base + 32'h0C;
        bus.rd_en = 1'b0;
        #1;
        check("no_rd_en", 64'(bus.rdata), 64'h0);

        // Asynchronous reset with irq pending
        bus_write(32'h00, 32'h0000_0000);
        bus_write(32'h04, 32'hFFFF_FFFF);
        bus_write(32'h08, 32'h0000_0003);
        @(posedge clk); #1;
        check("irq_pre_rst", 64'(irq), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_led", 64'(led), 64'h0);
        check("rst_mid_irq", 64'(irq), 64'h0);
        check("rst_mid_digi", 64'(digi), 64'(DigiDark));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_read(32'h04, rd); check("tl_after_rst", 64'(rd), 64'h0);
        bus_read(32'h08, rd); check("tcon_after_rst", 64'(rd), 64'h0);
        check("irq_after_rst", 64'(irq), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
